// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared constants and helpers for the conv window generator.
//               - c_STRIDE : output stride (2 when CONV_WIN_STRIDE2_EN is
//                            defined, otherwise 1)
//               - idx()    : packed window element index r*FILTER_SIZE+c
//               - cnt_w()  : counter width for a 0..n-1 counter
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

`ifdef CONV_WIN_STRIDE2_EN
   localparam int unsigned c_STRIDE = 2;
`else
   localparam int unsigned c_STRIDE = 1;
`endif

   function automatic int unsigned idx(input int unsigned fs,
                                       input int unsigned r,
                                       input int unsigned c);
      return r * fs + c;
   endfunction

   function automatic int unsigned cnt_w(input int unsigned n);
      return $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/conv_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : conv_line_buffer
// Description : DEPTH-deep delay line of DATA_BITS words. Each enabled cycle
//               shifts din_i in; dout_o is the word pushed DEPTH enables ago.
//               Contents are intentionally not reset.
// Ports       : clk    - clock
//               en_i   - shift enable (accepted pixel)
//               din_i  - word pushed in
//               dout_o - word delayed by DEPTH enabled cycles
// Revision    : 1.0 - initial release
// ============================================================================
module conv_line_buffer #(
   parameter int DEPTH     = 28,
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 en_i,
   input  logic [DATA_BITS-1:0] din_i,
   output logic [DATA_BITS-1:0] dout_o
);

   logic [DATA_BITS-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (en_i) begin
         mem_q[0] <= din_i;
         for (int i = 1; i < DEPTH; i++) begin
            mem_q[i] <= mem_q[i-1];
         end
      end
   end

   assign dout_o = mem_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/conv_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_gen
// Description : Raster pixel stream to sliding FILTER_SIZE x FILTER_SIZE window
//               generator (no padding). Buffers FILTER_SIZE-1 rows in chained
//               line buffers and emits one packed window per valid position,
//               one cycle after the completing pixel.
//               Optional macro CONV_WIN_STRIDE2_EN: only even output positions
//               are emitted and out_row/out_col report stride-2 indices.
// Ports       : clk, rst   - clock, synchronous active-high reset
//               pix_in     - signed pixel, raster order
//               pix_val    - pixel valid (no backpressure)
//               sof        - with pix_val: this pixel is (0,0)
//               win_out    - packed window, element r*FS+c at [i*DATA_BITS +:]
//               win_val    - one-cycle new-window strobe
//               out_row    - output-map row of the window
//               out_col    - output-map col of the window
//               frame_done - pulse after the last pixel of a frame
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_gen
   import conv_pkg::*;
#(
   parameter int FILTER_SIZE = 5,
   parameter int DATA_BITS   = 8,
   parameter int IMG_WIDTH   = 28,
   parameter int IMG_HEIGHT  = 28
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [DATA_BITS-1:0]                      pix_in,
   input  logic                                      pix_val,
   input  logic                                      sof,
   output logic [FILTER_SIZE*FILTER_SIZE*DATA_BITS-1:0] win_out,
   output logic                                      win_val,
   output logic [$clog2(IMG_HEIGHT)-1:0]             out_row,
   output logic [$clog2(IMG_WIDTH)-1:0]              out_col,
   output logic                                      frame_done
);

   localparam int FS = FILTER_SIZE;
   localparam int RW = cnt_w(IMG_HEIGHT);
   localparam int CW = cnt_w(IMG_WIDTH);
   localparam int WB = FS * FS * DATA_BITS;

   logic [RW-1:0]        row_q, row_d, w_row, w_orow;
   logic [CW-1:0]        col_q, col_d, w_col, w_ocol;
   logic                 w_win_ok, w_last;
   logic [DATA_BITS-1:0] lb_out [FS-1];   // lb_out[k] = pixel (k+1) rows above
   logic [DATA_BITS-1:0] w_newcol [FS];
   logic [DATA_BITS-1:0] win_q [FS][FS];
   logic [DATA_BITS-1:0] win_d [FS][FS];
   logic [WB-1:0]        w_pack, win_out_q;
   logic                 win_val_q, frame_done_q;
   logic [RW-1:0]        out_row_q;
   logic [CW-1:0]        out_col_q;

   // Line-buffer chain: each stage delays by one full row.
   for (genvar k = 0; k < FS - 1; k++) begin : g_lb
      logic [DATA_BITS-1:0] w_din;
      if (k == 0) begin : g_first
         assign w_din = pix_in;
      end else begin : g_next
         assign w_din = lb_out[k-1];
      end
      conv_line_buffer #(
         .DEPTH     (IMG_WIDTH),
         .DATA_BITS (DATA_BITS)
      ) u_lb (
         .clk    (clk),
         .en_i   (pix_val),
         .din_i  (w_din),
         .dout_o (lb_out[k])
      );
   end

   // sof re-bases the accepted pixel to (0,0) before any decision is made.
   assign w_row = sof ? '0 : row_q;
   assign w_col = sof ? '0 : col_q;

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (pix_val) begin
         if (w_col == CW'(IMG_WIDTH - 1)) begin
            col_d = '0;
            row_d = (w_row == RW'(IMG_HEIGHT - 1)) ? '0 : w_row + 1'b1;
         end else begin
            col_d = w_col + 1'b1;
            row_d = w_row;
         end
      end
   end

   assign w_last = pix_val && (w_row == RW'(IMG_HEIGHT - 1)) && (w_col == CW'(IMG_WIDTH - 1));

   // Output position at stride 1; halved when stride 2 is selected.
   always_comb begin
      w_orow   = w_row - RW'(FS - 1);
      w_ocol   = w_col - CW'(FS - 1);
      w_win_ok = pix_val && (w_row >= RW'(FS - 1)) && (w_col >= CW'(FS - 1));
      if (c_STRIDE == 2) begin
         w_win_ok = w_win_ok && !w_orow[0] && !w_ocol[0];
         w_orow   = w_orow >> 1;
         w_ocol   = w_ocol >> 1;
      end
   end

   // New right column: oldest row on top, live pixel at the bottom.
   always_comb begin
      w_newcol[FS-1] = pix_in;
      for (int r = 0; r < FS - 1; r++) begin
         w_newcol[r] = lb_out[FS-2-r];
      end
   end

   always_comb begin
      win_d = win_q;
      if (pix_val) begin
         for (int r = 0; r < FS; r++) begin
            for (int c = 0; c < FS - 1; c++) begin
               win_d[r][c] = win_q[r][c+1];
            end
            win_d[r][FS-1] = w_newcol[r];
         end
      end
   end

   always_comb begin
      w_pack = '0;
      for (int r = 0; r < FS; r++) begin
         for (int c = 0; c < FS; c++) begin
            w_pack[idx(FS, r, c)*DATA_BITS +: DATA_BITS] = win_d[r][c];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_q        <= '0;
         col_q        <= '0;
         win_q        <= '{default: '0};
         win_out_q    <= '0;
         win_val_q    <= 1'b0;
         out_row_q    <= '0;
         out_col_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         row_q        <= row_d;
         col_q        <= col_d;
         win_q        <= win_d;
         win_val_q    <= w_win_ok;
         frame_done_q <= w_last;
         if (w_win_ok) begin
            win_out_q <= w_pack;
            out_row_q <= w_orow;
            out_col_q <= w_ocol;
         end
      end
   end

   assign win_out    = win_out_q;
   assign win_val    = win_val_q;
   assign out_row    = out_row_q;
   assign out_col    = out_col_q;
   assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_window_gen
// Description : Directed self-checking bench for conv_window_gen with
//               FILTER_SIZE=3, 5x5 image, pixel = base + row*5 + col.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_gen;

   localparam int FS = 3;
   localparam int W  = 5;
   localparam int H  = 5;
   localparam int DB = 8;
`ifdef CONV_WIN_STRIDE2_EN
   localparam int STRIDE   = 2;
   localparam int EXP_NWIN = 4;
`else
   localparam int STRIDE   = 1;
   localparam int EXP_NWIN = 9;
`endif

   logic                 clk = 1'b0;
   logic                 rst;
   logic [DB-1:0]        pix_in;
   logic                 pix_val;
   logic                 sof;
   logic [FS*FS*DB-1:0]  win_out;
   logic                 win_val;
   logic [2:0]           out_row;
   logic [2:0]           out_col;
   logic                 frame_done;

   int n_checks = 0;
   int n_fail   = 0;
   int m_row = 0, m_col = 0;
   int n_win, n_fd;
   logic [DB-1:0]       img [H][W];
   logic [FS*FS*DB-1:0] last_win, first_win, final_win;
   int last_orow, last_ocol;

   always #5 clk = ~clk;

   conv_window_gen #(
      .FILTER_SIZE (FS),
      .DATA_BITS   (DB),
      .IMG_WIDTH   (W),
      .IMG_HEIGHT  (H)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pix_in     (pix_in),
      .pix_val    (pix_val),
      .sof        (sof),
      .win_out    (win_out),
      .win_val    (win_val),
      .out_row    (out_row),
      .out_col    (out_col),
      .frame_done (frame_done)
   );

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One accepted pixel; checks the registered outputs one cycle later.
   task automatic push(input logic [DB-1:0] p, input bit s);
      int r, c;
      bit exp_v;
      logic [FS*FS*DB-1:0] exp_w;
      r = s ? 0 : m_row;
      c = s ? 0 : m_col;
      img[r][c] = p;
      pix_in  = p;
      pix_val = 1'b1;
      sof     = s;
      @(posedge clk); #1;
      pix_val = 1'b0;
      sof     = 1'b0;
      exp_v = (r >= FS-1) && (c >= FS-1) && ((r-FS+1) % STRIDE == 0) && ((c-FS+1) % STRIDE == 0);
      check_eq("win_val", win_val, exp_v);
      check_eq("frame_done", frame_done, (r == H-1) && (c == W-1));
      if (exp_v) begin
         exp_w = '0;
         for (int i = 0; i < FS; i++)
            for (int j = 0; j < FS; j++)
               exp_w[(i*FS+j)*DB +: DB] = img[r-FS+1+i][c-FS+1+j];
         last_win  = exp_w;
         last_orow = (r-FS+1) / STRIDE;
         last_ocol = (c-FS+1) / STRIDE;
         check_eq("win_out", win_out, exp_w);
         check_eq("out_row", out_row, last_orow);
         check_eq("out_col", out_col, last_ocol);
         n_win++;
         if (n_win == 1) first_win = win_out;
         final_win = win_out;
      end
      if (frame_done) n_fd++;
      if (c == W-1) begin
         m_col = 0;
         m_row = (r == H-1) ? 0 : r + 1;
      end else begin
         m_col = c + 1;
         m_row = r;
      end
   endtask

   // Idle cycles: no strobes, outputs hold.
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         check_eq("gap_win_val", win_val, 1'b0);
         check_eq("gap_frame_done", frame_done, 1'b0);
         check_eq("gap_win_hold", win_out, last_win);
         check_eq("gap_row_hold", out_row, last_orow);
         check_eq("gap_col_hold", out_col, last_ocol);
      end
   endtask

   task automatic send_frame(input logic [DB-1:0] base, input bit gaps, input bit use_sof);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            push(DB'(base + r*W + c), use_sof && r == 0 && c == 0);
            if (gaps) idle($urandom_range(1, 3));
         end
   endtask

   task automatic clr_counts();
      n_win = 0;
      n_fd  = 0;
   endtask

   initial begin
      rst = 1'b1; pix_val = 1'b0; sof = 1'b0; pix_in = '0;
      last_win = '0; last_orow = 0; last_ocol = 0;
      first_win = '0; final_win = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_win_out", win_out, 0);
      check_eq("rst_win_val", win_val, 0);
      check_eq("rst_out_row", out_row, 0);
      check_eq("rst_out_col", out_col, 0);
      check_eq("rst_frame_done", frame_done, 0);
      rst = 1'b0;
      idle(2);

      // Continuous frame
      clr_counts();
      send_frame(8'h00, 1'b0, 1'b1);
      idle(1);
      check_eq("t1_nwin", n_win, EXP_NWIN);
      check_eq("t1_nfd", n_fd, 1);
      check_eq("t1_first", first_win, 72'h0c0b0a070605020100);
      check_eq("t1_last", final_win, 72'h1817161312110e0d0c);

      // Same frame with gaps
      clr_counts();
      send_frame(8'h00, 1'b1, 1'b1);
      check_eq("t2_nwin", n_win, EXP_NWIN);
      check_eq("t2_nfd", n_fd, 1);
      check_eq("t2_first", first_win, 72'h0c0b0a070605020100);

      // Abort after 8 pixels with sof
      clr_counts();
      for (int i = 0; i < 8; i++) push(DB'(100 + i), 1'b0);
      clr_counts();
      send_frame(8'h00, 1'b0, 1'b1);
      check_eq("t4_nwin", n_win, EXP_NWIN);
      check_eq("t4_nfd", n_fd, 1);
      check_eq("t4_last", final_win, 72'h1817161312110e0d0c);

      // Reset at pixel 18
      clr_counts();
      for (int i = 0; i < 18; i++) push(DB'(i), 1'b0);
      pix_in = 8'd18; pix_val = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      pix_val = 1'b0; rst = 1'b0;
      check_eq("t5_win_out", win_out, 0);
      check_eq("t5_win_val", win_val, 0);
      check_eq("t5_out_row", out_row, 0);
      check_eq("t5_out_col", out_col, 0);
      check_eq("t5_frame_done", frame_done, 0);
      m_row = 0; m_col = 0; last_win = '0; last_orow = 0; last_ocol = 0;
      idle(1);
      clr_counts();
      send_frame(8'h00, 1'b0, 1'b0);
      check_eq("t5_nwin", n_win, EXP_NWIN);
      check_eq("t5_first", first_win, 72'h0c0b0a070605020100);
      check_eq("t5_last", final_win, 72'h1817161312110e0d0c);

      // Negative pixels pass through bit-exact
      clr_counts();
      send_frame(8'h80, 1'b0, 1'b1);
      check_eq("t6_nwin", n_win, EXP_NWIN);
      check_eq("t6_first", first_win, 72'h8c8b8a878685828180);
      check_eq("t6_elem0", first_win[7:0], 8'h80);
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
